float32_arith_unit: RTL and testbench

Registered single-precision (IEEE-754 binary32) arithmetic unit. Presents one operand pair and produces sum, difference, product and quotient in parallel, one clock after capture. Sits beside the integer datapath as the shared floating-point resource for model/inference logic.

---
 rtl/float32_pkg.sv | 70 +++++++
 rtl/float32_add_core.sv | 75 +++++++
 rtl/float32_arith_unit.sv | 105 ++++++++++
 tb/tb_float32_arith_unit.sv | 107 ++++++++++
 4 files changed

// File: rtl/float32_pkg.sv
// Shared binary32 field definitions, special-class decoding and round/pack helpers
// used by the add cores and the multiply/divide datapath.
package float32_pkg;

  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;
  localparam int SIG_W  = FRAC_W + 1;
  localparam int BIAS   = 127;

  localparam logic [31:0] QNAN    = 32'h7FC0_0000;
  localparam logic [31:0] POS_INF = 32'h7F80_0000;

  typedef enum logic [1:0] {CLS_ZERO, CLS_NORM, CLS_INF, CLS_NAN} fclass_t;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [SIG_W-1:0] sig;
    fclass_t          cls;
  } fp_t;

  // Subnormal encodings are classed as zero so they never reach the datapath.
  function automatic fp_t unpack(input logic [31:0] x);
    fp_t u;
    u.sign = x[31];
    u.exp  = x[30:23];
    u.sig  = {1'b1, x[22:0]};
    if (x[30:23] == 8'h00)
      u.cls = CLS_ZERO;
    else if (x[30:23] == 8'hFF)
      u.cls = (x[22:0] != 23'd0) ? CLS_NAN : CLS_INF;
    else
      u.cls = CLS_NORM;
    return u;
  endfunction

  // Result bit SIG_W is the carry out of rounding.
  function automatic logic [SIG_W:0] round_rne(input logic [SIG_W-1:0] sig,
                                               input logic guard,
                                               input logic rnd,
                                               input logic sticky);
    logic inc;
    inc = guard & (rnd | sticky | sig[0]);
    return {1'b0, sig} + {{SIG_W{1'b0}}, inc};
  endfunction

  // Rounds a normalised significand and saturates to Inf or flushes to zero.
  function automatic logic [31:0] pack(input logic              sign,
                                       input logic signed [9:0] exp_in,
                                       input logic [SIG_W-1:0]  sig,
                                       input logic              guard,
                                       input logic              rnd,
                                       input logic              sticky);
    logic [SIG_W:0]    rounded;
    logic signed [9:0] e;
    logic [FRAC_W-1:0] frac;
    logic [31:0]       result;
    rounded = round_rne(sig, guard, rnd, sticky);
    e       = rounded[SIG_W] ? exp_in + 10'sd1 : exp_in;
    frac    = rounded[SIG_W] ? rounded[SIG_W-1:1] : rounded[FRAC_W-1:0];
    if (e >= 10'sd255)
      result = POS_INF | {sign, 31'd0};
    else if (e <= 10'sd0)
      result = {sign, 31'd0};
    else
      result = {sign, e[7:0], frac};
    return result;
  endfunction

endpackage

// File: rtl/float32_add_core.sv
// Combinational binary32 adder: align, add/subtract with guard/round/sticky,
// renormalise and round to nearest even.
module float32_add_core
  import float32_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] sum
);

  fp_t               ua, ub;
  logic              swap;
  logic              big_sign, small_sign;
  logic [7:0]        big_exp, small_exp, diff;
  logic [23:0]       big_sig, small_sig;
  logic [4:0]        shamt, lz;
  logic [49:0]       shifted;
  logic              sticky;
  logic [27:0]       big_ext, small_ext, res;
  logic [26:0]       norm;
  logic [31:0]       normal_sum;

  assign ua   = unpack(a);
  assign ub   = unpack(b);
  assign swap = (b[30:0] > a[30:0]);

  always_comb begin
    big_sign   = swap ? ub.sign : ua.sign;
    small_sign = swap ? ua.sign : ub.sign;
    big_exp    = swap ? ub.exp  : ua.exp;
    small_exp  = swap ? ua.exp  : ub.exp;
    big_sig    = swap ? ub.sig  : ua.sig;
    small_sig  = swap ? ua.sig  : ub.sig;
    diff       = big_exp - small_exp;
    // Beyond 26 places the whole small significand already lands in sticky.
    shamt      = (diff > 8'd26) ? 5'd26 : diff[4:0];
    shifted    = {small_sig, 26'd0} >> shamt;
    sticky     = |shifted[23:0];
    big_ext    = {1'b0, big_sig, 3'b000};
    small_ext  = {1'b0, shifted[49:24], sticky};
    res        = (big_sign == small_sign) ? big_ext + small_ext : big_ext - small_ext;

    lz = 5'd0;
    for (int i = 0; i <= 26; i++)
      if (res[i]) lz = 5'(26 - i);
    norm = res[26:0] << lz;

    if (res[27])
      normal_sum = pack(big_sign, $signed({2'b00, big_exp}) + 10'sd1,
                        res[27:4], res[3], res[2], |res[1:0]);
    else if (res == 28'd0)
      normal_sum = 32'h0000_0000;
    else
      normal_sum = pack(big_sign, $signed({2'b00, big_exp}) - $signed({5'd0, lz}),
                        norm[26:3], norm[2], norm[1], norm[0]);

    if (ua.cls == CLS_NAN || ub.cls == CLS_NAN)
      sum = QNAN;
    else if (ua.cls == CLS_INF && ub.cls == CLS_INF)
      sum = (ua.sign != ub.sign) ? QNAN : a;
    else if (ua.cls == CLS_INF)
      sum = a;
    else if (ub.cls == CLS_INF)
      sum = b;
    else if (ua.cls == CLS_ZERO && ub.cls == CLS_ZERO)
      sum = {ua.sign & ub.sign, 31'd0};
    else if (ua.cls == CLS_ZERO)
      sum = b;
    else if (ub.cls == CLS_ZERO)
      sum = a;
    else
      sum = normal_sum;
  end

endmodule

// File: rtl/float32_arith_unit.sv
// Registered binary32 unit: add, subtract, multiply and divide of one operand
// pair computed in parallel, results one clock after capture.
module float32_arith_unit
  import float32_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  output logic        out_valid,
  output logic [31:0] out_add,
  output logic [31:0] out_sub,
  output logic [31:0] out_mul,
  output logic [31:0] out_div
);

  fp_t               ua, ub;
  logic              sign_x;
  logic [1:0][31:0]  sums;
  logic [47:0]       prod;
  logic signed [9:0] mul_exp, div_exp;
  logic [31:0]       mul_norm, mul_res, div_norm, div_res;
  logic [26:0]       quo;
  logic [24:0]       rem;

  assign ua     = unpack(in_a);
  assign ub     = unpack(in_b);
  assign sign_x = ua.sign ^ ub.sign;

  // Instance 1 sees B with its sign flipped, giving A - B.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_add
      float32_add_core u_add (
        .a   (in_a),
        .b   ({in_b[31] ^ (gi == 1), in_b[30:0]}),
        .sum (sums[gi])
      );
    end
  endgenerate

  always_comb begin
    prod    = {24'd0, ua.sig} * {24'd0, ub.sig};
    mul_exp = $signed({2'b00, ua.exp}) + $signed({2'b00, ub.exp}) - 10'sd127;
    if (prod[47])
      mul_norm = pack(sign_x, mul_exp + 10'sd1, prod[47:24], prod[23], prod[22], |prod[21:0]);
    else
      mul_norm = pack(sign_x, mul_exp, prod[46:23], prod[22], prod[21], |prod[20:0]);

    if (ua.cls == CLS_NAN || ub.cls == CLS_NAN ||
        (ua.cls == CLS_INF && ub.cls == CLS_ZERO) || (ua.cls == CLS_ZERO && ub.cls == CLS_INF))
      mul_res = QNAN;
    else if (ua.cls == CLS_INF || ub.cls == CLS_INF)
      mul_res = POS_INF | {sign_x, 31'd0};
    else if (ua.cls == CLS_ZERO || ub.cls == CLS_ZERO)
      mul_res = {sign_x, 31'd0};
    else
      mul_res = mul_norm;
  end

  // Restoring division: 27 quotient bits, ratio of significands lies in (0.5, 2).
  always_comb begin
    rem = {1'b0, ua.sig};
    quo = '0;
    for (int i = 26; i >= 0; i--) begin
      if (rem >= {1'b0, ub.sig}) begin
        quo[i] = 1'b1;
        rem    = rem - {1'b0, ub.sig};
      end
      rem = rem << 1;
    end
    div_exp = $signed({2'b00, ua.exp}) - $signed({2'b00, ub.exp}) + 10'sd127;
    if (quo[26])
      div_norm = pack(sign_x, div_exp, quo[26:3], quo[2], quo[1], quo[0] | (rem != 25'd0));
    else
      div_norm = pack(sign_x, div_exp - 10'sd1, quo[25:2], quo[1], quo[0], rem != 25'd0);

    if (ua.cls == CLS_NAN || ub.cls == CLS_NAN ||
        (ua.cls == CLS_INF && ub.cls == CLS_INF) || (ua.cls == CLS_ZERO && ub.cls == CLS_ZERO))
      div_res = QNAN;
    else if (ua.cls == CLS_INF || ub.cls == CLS_ZERO)
      div_res = POS_INF | {sign_x, 31'd0};
    else if (ua.cls == CLS_ZERO || ub.cls == CLS_INF)
      div_res = {sign_x, 31'd0};
    else
      div_res = div_norm;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_add   <= 32'd0;
      out_sub   <= 32'd0;
      out_mul   <= 32'd0;
      out_div   <= 32'd0;
    end else begin
      out_valid <= in_valid;
      out_add   <= sums[0];
      out_sub   <= sums[1];
      out_mul   <= mul_res;
      out_div   <= div_res;
    end
  end

endmodule

// File: tb/tb_float32_arith_unit.sv
// Directed-vector bench for float32_arith_unit; inputs change on the falling
// edge and results are sampled on the following falling edge.
module tb_float32_arith_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [31:0] in_a, in_b;
  logic        out_valid;
  logic [31:0] out_add, out_sub, out_mul, out_div;

  int checks = 0;
  int errors = 0;

  float32_arith_unit dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_add   (out_add),
    .out_sub   (out_sub),
    .out_mul   (out_mul),
    .out_div   (out_div)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want)
    else begin
      errors++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, want);
    end
  endtask

  // Drives one operand pair at the current falling edge, checks one cycle later.
  task automatic run(input string tag, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] e_add, input logic [31:0] e_sub,
                     input logic [31:0] e_mul, input logic [31:0] e_div);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    @(negedge clock);
    chk({tag, " valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, " add"}, out_add, e_add);
    chk({tag, " sub"}, out_sub, e_sub);
    chk({tag, " mul"}, out_mul, e_mul);
    chk({tag, " div"}, out_div, e_div);
    $display("vec %-10s a=%08h b=%08h add=%08h sub=%08h mul=%08h div=%08h",
             tag, a, b, out_add, out_sub, out_mul, out_div);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, " add"}, out_add, 32'd0);
    chk({tag, " sub"}, out_sub, 32'd0);
    chk({tag, " mul"}, out_mul, 32'd0);
    chk({tag, " div"}, out_div, 32'd0);
    $display("rst %-10s valid=%0d add=%08h sub=%08h mul=%08h div=%08h",
             tag, out_valid, out_add, out_sub, out_mul, out_div);
  endtask

  initial begin
    reset    = 1'b1;
    in_valid = 1'b1;
    in_a     = 32'h4122_0000;
    in_b     = 32'h3E00_0000;
    repeat (2) @(negedge clock);
    chk_zero("reset");
    reset = 1'b0;

    run("base",    32'h4122_0000, 32'h3E00_0000, 32'h4124_0000, 32'h4120_0000, 32'h3FA2_0000, 32'h42A2_0000);
    run("neg_a",   32'hC122_0000, 32'h3E00_0000, 32'hC120_0000, 32'hC124_0000, 32'hBFA2_0000, 32'hC2A2_0000);
    run("neg_b",   32'h4122_0000, 32'hBE00_0000, 32'h4120_0000, 32'h4124_0000, 32'hBFA2_0000, 32'hC2A2_0000);
    run("swap",    32'h3E00_0000, 32'h4122_0000, 32'h4124_0000, 32'hC120_0000, 32'h3FA2_0000, 32'h3C4A_4588);
    run("swap_na", 32'hBE00_0000, 32'h4122_0000, 32'h4120_0000, 32'hC124_0000, 32'hBFA2_0000, 32'hBC4A_4588);
    run("rne",     32'h4522_0000, 32'hC680_0001, 32'hC657_8002, 32'h4694_4001, 32'hCC22_0001, 32'hBE21_FFFF);
    run("nan",     32'h7FC0_0000, 32'h3F80_0000, 32'h7FC0_0000, 32'h7FC0_0000, 32'h7FC0_0000, 32'h7FC0_0000);
    run("div0",    32'h3F80_0000, 32'h0000_0000, 32'h3F80_0000, 32'h3F80_0000, 32'h0000_0000, 32'h7F80_0000);
    run("zero0",   32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000);
    run("ovf",     32'h7F7F_FFFF, 32'h4000_0000, 32'h7F7F_FFFF, 32'h7F7F_FFFF, 32'h7F80_0000, 32'h7EFF_FFFF);
    run("cancel",  32'h4122_0000, 32'h4122_0000, 32'h41A2_0000, 32'h0000_0000, 32'h42CD_0800, 32'h3F80_0000);
    run("undf",    32'h0080_0000, 32'h3F00_0000, 32'h3F00_0000, 32'hBF00_0000, 32'h0000_0000, 32'h0100_0000);

    // Back-to-back stream with reset on the second cycle.
    run("b2b_1",   32'h4122_0000, 32'h3E00_0000, 32'h4124_0000, 32'h4120_0000, 32'h3FA2_0000, 32'h42A2_0000);
    reset    = 1'b1;
    in_valid = 1'b1;
    in_a     = 32'h4522_0000;
    in_b     = 32'hC680_0001;
    @(negedge clock);
    chk_zero("b2b_rst");
    reset = 1'b0;
    run("b2b_3",   32'h4522_0000, 32'hC680_0001, 32'hC657_8002, 32'h4694_4001, 32'hCC22_0001, 32'hBE21_FFFF);
    run("b2b_4",   32'hC122_0000, 32'h3E00_0000, 32'hC120_0000, 32'hC124_0000, 32'hBFA2_0000, 32'hC2A2_0000);
    in_valid = 1'b0;
    @(negedge clock);
    chk("idle valid", {31'd0, out_valid}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
